if_stage: RTL
=============

IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL provide parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 SHALL provide ports, clock and reset first:
- CLK  in  1  the single clock; all state changes on its rising edge.
- RST  in  1  asynchronous, active-high reset.
- freeze  in  1  hazard stall from the hazard-detect unit; holds PC and the IF/ID outputs.
- Branch_taken  in  1  one-cycle redirect request from EXE.
- Branch_Address  in  32  redirect target.
- imem_req  out  1  instruction-memory request.
- imem_addr  out  32  word-aligned fetch address.
- imem_ack  in  1  memory completion; rdata valid in the same cycle.
- imem_rdata  in  32  fetched instruction word.
- PC_Out  out  32  fetch address + 4 of the instruction presented to ID.
- Instruction  out  32  instruction presented to ID.
- Valid  out  1  Instruction/PC_Out hold a real instruction, not a bubble.

Function
REQ-003 SHALL hold a 32-bit PC register, with next PC = PC + 4 modulo 2^32.
REQ-004 SHALL force Branch_Address[1:0] to 2'b00 before use.
REQ-005 SHALL implement the FSM states FETCH, DRAIN and HOLD.
REQ-006 FETCH: imem_req=1 and imem_addr=PC; a cycle with imem_req=1 and imem_ack=1 completes a fetch.
REQ-007 Once imem_req rises, imem_req and imem_addr SHALL stay stable until the ack cycle, whatever freeze or Branch_taken do.
REQ-008 Completion in FETCH with freeze=0 and Branch_taken=0 SHALL, at the next edge:
- load Instruction=imem_rdata, PC_Out=PC+4 and Valid=1;
- set PC=PC+4 and remain in FETCH.
The next request is therefore issued in the following cycle, giving 1 instruction per cycle with zero-wait memory.
REQ-009 Completion with freeze=1 and Branch_taken=0 SHALL:
- capture imem_rdata into a one-entry hold buffer;
- go to HOLD with imem_req=0 and leave the IF/ID outputs unchanged.
REQ-010 HOLD with freeze=0 SHALL, at the next edge:
- move the buffer into the IF/ID outputs with Valid=1;
- set PC=PC+4 and go to FETCH.
REQ-011 In FETCH with no completion, freeze=0 SHALL load Valid=0 and Instruction=32'h0 (bubble), and freeze=1 SHALL hold the IF/ID outputs.
REQ-012 Branch_taken=1 SHALL:
- flush the IF/ID outputs (Valid=0, Instruction=0), taking priority over freeze;
- set PC=Branch_Address.
The follow-up depends on the memory state:
- ack in the same cycle, or in HOLD: discard the fetched or held word and go to FETCH, requesting the target next cycle.
- request outstanding without ack: go to DRAIN.
REQ-013 DRAIN SHALL keep the old request until ack, discard that data, then go to FETCH with the target address.
REQ-014 A second Branch_taken during DRAIN SHALL overwrite the pending target; the last one wins.
REQ-015 freeze SHALL never block a flush, and SHALL NOT stall DRAIN completion.

Reset
REQ-016 RST=1 SHALL asynchronously set:
- PC=RESET_PC and state=FETCH;
- PC_Out=0, Instruction=0 and Valid=0;
- the hold buffer to 0.
REQ-017 Reset mid-handshake SHALL abandon the outstanding request; the first request after RST falls is to RESET_PC.
REQ-018 imem_req SHALL be 0 while RST=1.

Structure
REQ-019 A shared package SHALL hold:
- the FSM state type;
- PC_INC=4;
- NOP_INSTR=32'h0;
- the address and data widths (32).
REQ-020 The IF/ID pipeline register (load, hold and flush of PC_Out/Instruction/Valid) SHALL be a sub-module named if_id_reg; the PC, FSM and hold buffer stay in if_stage.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Zero-wait memory, ack always 1, rdata=addr ^ 32'hA5A5_0000, 4 cycles after reset: imem_addr 0,4,8,C, with PC_Out 4,8,C,10 and Valid=1 one cycle later.
- Ack delayed 2 cycles at addr 8: addr 8 stable for 3 cycles, 2 bubbles (Valid=0), then Instruction=32'hA5A5_0008 and PC_Out=C.
- freeze=1 on the ack cycle for addr 4, held 3 cycles: outputs keep the addr-0 instruction, imem_req=0, and after release Instruction=32'hA5A5_0004 and PC_Out=8.
- Branch_taken with Branch_Address=32'h0000_0103 while the addr-C request waits 2 cycles: addr C held until ack and its data discarded, next request 32'h0000_0100, Valid=0 until that completes.
- RST pulsed mid-wait at addr 10: outputs 0 immediately, first post-reset request to 0; PC wrap check, with RESET_PC=32'hFFFF_FFFC giving next addr 0 and PC_Out=0.

Source files
------------

// File: rtl/if_stage_pkg.sv
// Shared definitions for the instruction-fetch stage.
// Holds the bus widths, PC increment, bubble encoding, fetch FSM state type,
// the IF/ID load payload and a word-alignment helper.
package if_stage_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;

    localparam logic [ADDR_W-1:0] PC_INC    = ADDR_W'(4);
    localparam logic [DATA_W-1:0] NOP_INSTR = DATA_W'(0);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        DRAIN = 2'd1,
        HOLD  = 2'd2
    } fetch_state_e;

    // Payload loaded into the IF/ID register
    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [DATA_W-1:0] instr;
    } if_id_t;

    // Clear the byte-offset bits of an address
    function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
        return addr & ~ADDR_W'(3);
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register.
// Ports: clk/rst (async active-high), load (capture d), flush (insert bubble,
// wins over load), d (pc + instruction payload), pc_out/instr/valid (to ID).
// With neither load nor flush the register holds its contents.
module if_id_reg
    import if_stage_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              flush,
    input  if_id_t            d,
    output logic [ADDR_W-1:0] pc_out,
    output logic [DATA_W-1:0] instr,
    output logic              valid
);

    // Flush keeps pc_out; only valid/instr mark the bubble
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_out <= '0;
            instr  <= NOP_INSTR;
            valid  <= 1'b0;
        end else if (flush) begin
            instr  <= NOP_INSTR;
            valid  <= 1'b0;
        end else if (load) begin
            pc_out <= d.pc;
            instr  <= d.instr;
            valid  <= 1'b1;
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC, fetch FSM (FETCH/DRAIN/HOLD), one-entry hold
// buffer and the IF/ID register.
// Ports: CLK/RST (async active-high), freeze (stall from hazard unit),
// Branch_taken/Branch_Address (redirect from EXE), imem_req/imem_addr/
// imem_ack/imem_rdata (instruction memory handshake), PC_Out/Instruction/
// Valid (to ID).
// imem_req/imem_addr are registered; once a request is up it is only changed
// on its ack cycle, so the first request after reset appears one cycle after
// RST falls.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              freeze,
    input  logic              Branch_taken,
    input  logic [ADDR_W-1:0] Branch_Address,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic [ADDR_W-1:0] PC_Out,
    output logic [DATA_W-1:0] Instruction,
    output logic              Valid
);

    fetch_state_e      state;
    logic [ADDR_W-1:0] pc;        // fetch address, or pending target while draining
    logic [DATA_W-1:0] hold_buf;

    logic [ADDR_W-1:0] br_target_c;
    logic [ADDR_W-1:0] pc_seq_c;
    logic              done_c;
    logic              id_load_c;
    logic              id_flush_c;
    if_id_t            id_d_c;

    assign br_target_c = word_align(Branch_Address);
    assign pc_seq_c    = pc + PC_INC;
    assign done_c      = imem_req & imem_ack;

    // IF/ID control for the coming edge
    always_comb begin
        id_load_c        = 1'b0;
        id_flush_c       = 1'b0;
        id_d_c.pc        = pc_seq_c;
        id_d_c.instr     = imem_rdata;
        unique case (state)
            FETCH: begin
                if (Branch_taken) begin
                    id_flush_c = 1'b1;
                end else if (!freeze) begin
                    // completion loads the word, otherwise a bubble
                    id_load_c  = done_c;
                    id_flush_c = !done_c;
                end
            end
            HOLD: begin
                id_d_c.instr = hold_buf;
                if (Branch_taken) begin
                    id_flush_c = 1'b1;
                end else if (!freeze) begin
                    id_load_c = 1'b1;
                end
            end
            DRAIN: begin
                id_flush_c = 1'b1;
            end
            default: begin
                id_flush_c = 1'b1;
            end
        endcase
    end

    // Fetch FSM, PC, hold buffer and memory request
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= FETCH;
            pc        <= RESET_PC;
            hold_buf  <= '0;
            imem_req  <= 1'b0;
            imem_addr <= RESET_PC;
        end else begin
            unique case (state)
                FETCH: begin
                    if (Branch_taken) begin
                        pc <= br_target_c;
                        if (imem_req && !imem_ack) begin
                            // old request must finish before the target goes out
                            state <= DRAIN;
                        end else begin
                            imem_req  <= 1'b1;
                            imem_addr <= br_target_c;
                        end
                    end else if (done_c) begin
                        if (freeze) begin
                            state    <= HOLD;
                            hold_buf <= imem_rdata;
                            imem_req <= 1'b0;
                        end else begin
                            pc        <= pc_seq_c;
                            imem_addr <= pc_seq_c;
                        end
                    end else begin
                        // also raises the first request after reset
                        imem_req  <= 1'b1;
                        imem_addr <= pc;
                    end
                end
                HOLD: begin
                    if (Branch_taken) begin
                        state     <= FETCH;
                        pc        <= br_target_c;
                        imem_req  <= 1'b1;
                        imem_addr <= br_target_c;
                    end else if (!freeze) begin
                        state     <= FETCH;
                        pc        <= pc_seq_c;
                        imem_req  <= 1'b1;
                        imem_addr <= pc_seq_c;
                    end
                end
                DRAIN: begin
                    // last redirect wins; freeze does not stall the drain
                    if (Branch_taken) begin
                        pc <= br_target_c;
                    end
                    if (done_c) begin
                        state     <= FETCH;
                        imem_addr <= Branch_taken ? br_target_c : pc;
                    end
                end
                default: begin
                    state <= FETCH;
                end
            endcase
        end
    end

    if_id_reg u_if_id_reg (
        .clk    (CLK),
        .rst    (RST),
        .load   (id_load_c),
        .flush  (id_flush_c),
        .d      (id_d_c),
        .pc_out (PC_Out),
        .instr  (Instruction),
        .valid  (Valid)
    );

endmodule
